mcpu5_feeder: RTL

Program feeder and clock sequencer that sits directly upstream of the MCPU5 core. It drives the core's `clk`, `rst` and 6-bit `inst_in` pins from a small writable program memory. It demultiplexes the core's time-shared 8-bit output bus: PC while the core clock is high, accumulator while it is low. It captures the accumulator on every `OUT` instruction and presents it as a one-cycle result strobe.

---
 rtl/mcpu5_pkg.sv | 19 +
 rtl/mcpu5_prog_mem.sv | 23 ++
 rtl/mcpu5_feeder.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/mcpu5_pkg.sv
// rtl/mcpu5_pkg.sv - shared opcodes, feeder FSM states and limits for the MCPU5 feeder
package mcpu5_pkg;

  localparam logic [5:0] OP_OUT = 6'b111001;
  localparam logic [2:0] OP_STA = 3'b101;
  localparam logic [1:0] OP_LDI = 2'b01;

  localparam int PHASE_LEN_MIN = 2;

  typedef enum logic [2:0] {
    IDLE,
    RST_HI,
    RST_LO,
    HI,
    LO,
    PARK
  } feeder_state_e;

endpackage

// File: rtl/mcpu5_prog_mem.sv
// rtl/mcpu5_prog_mem.sv - program word store, synchronous write, asynchronous read, no reset
module mcpu5_prog_mem #(
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [5:0]        i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [5:0]        o_rdata
);

  logic [5:0] r_mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/mcpu5_feeder.sv
// rtl/mcpu5_feeder.sv - clocks the MCPU5 core from program memory and demuxes its PC/ACC bus
module mcpu5_feeder
  import mcpu5_pkg::*;
#(
  parameter int ADDR_W    = 4,
  parameter int PHASE_LEN = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run_i,
  input  logic              prog_we_i,
  input  logic [ADDR_W-1:0] prog_addr_i,
  input  logic [5:0]        prog_data_i,
  output logic              cpu_clk_o,
  output logic              cpu_rst_o,
  output logic [5:0]        cpu_inst_o,
  input  logic [7:0]        cpu_bus_i,
  output logic [7:0]        out_data_o,
  output logic              out_valid_o,
  output logic [15:0]       cyc_o
);

  localparam int PL   = (PHASE_LEN < PHASE_LEN_MIN) ? PHASE_LEN_MIN : PHASE_LEN;
  localparam int PH_W = $clog2(PL);
  localparam logic [PH_W-1:0] PH_SAMP = PH_W'(PL - 2);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(PL - 1);

  feeder_state_e   r_state, w_next_state;
  logic [PH_W-1:0] r_phase;
  logic            r_rst_cnt;
  logic [5:0]      r_inst;
  logic [7:0]      r_out_data;
  logic            r_out_valid;
  logic [15:0]     r_cyc;
  logic            w_mem_we;
  logic [5:0]      w_mem_rdata;
  logic            w_samp;
  logic            w_last;

  assign w_samp = (r_phase == PH_SAMP);
  assign w_last = (r_phase == PH_LAST);

  mcpu5_prog_mem #(.ADDR_W(ADDR_W)) u_mem (
    .clk     (clk),
    .i_we    (w_mem_we),
    .i_waddr (prog_addr_i),
    .i_wdata (prog_data_i),
    .i_raddr (cpu_bus_i[ADDR_W-1:0]),
    .o_rdata (w_mem_rdata)
  );

  // Leaving reset jumps into the final high-phase cycle so cpu_rst_o drops while cpu_clk_o is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_phase   <= '0;
      r_rst_cnt <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (r_state == RST_HI && w_next_state == HI) begin
        r_phase <= PH_LAST;
      end else if (w_next_state != r_state) begin
        r_phase <= '0;
      end else if (r_state inside {RST_HI, RST_LO, HI, LO}) begin
        r_phase <= r_phase + PH_W'(1);
      end else begin
        r_phase <= '0;
      end
      if (r_state == IDLE) begin
        r_rst_cnt <= 1'b0;
      end else if (r_state == RST_LO) begin
        r_rst_cnt <= 1'b1;
      end
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (run_i) w_next_state = RST_HI;
      RST_HI: begin
        if (r_rst_cnt && w_samp) begin
          w_next_state = HI;
        end else if (w_last) begin
          w_next_state = RST_LO;
        end
      end
      RST_LO:  if (w_last) w_next_state = RST_HI;
      HI: begin
        if (w_samp && !run_i) begin
          w_next_state = PARK;
        end else if (w_last) begin
          w_next_state = LO;
        end
      end
      LO:      if (w_last) w_next_state = HI;
      PARK:    if (run_i) w_next_state = LO;
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    cpu_clk_o = 1'b0;
    cpu_rst_o = 1'b0;
    w_mem_we  = 1'b0;
    case (r_state)
      IDLE: begin
        cpu_rst_o = 1'b1;
        w_mem_we  = prog_we_i;
      end
      RST_HI: begin
        cpu_clk_o = 1'b1;
        cpu_rst_o = 1'b1;
      end
      RST_LO:  cpu_rst_o = 1'b1;
      HI:      cpu_clk_o = 1'b1;
      PARK: begin
        cpu_clk_o = 1'b1;
        w_mem_we  = prog_we_i;
      end
      default: ;
    endcase
  end

  // Fetch on the high-phase sample point; capture ACC and count on the last low-phase cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inst      <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_cyc       <= '0;
    end else begin
      r_out_valid <= 1'b0;
      if ((r_state == HI || r_state == RST_HI) && w_samp) begin
        r_inst <= w_mem_rdata;
      end
      if (r_state == LO && w_last) begin
        if (r_inst == OP_OUT) begin
          r_out_data  <= cpu_bus_i;
          r_out_valid <= 1'b1;
        end
        if (r_cyc != 16'hFFFF) begin
          r_cyc <= r_cyc + 16'd1;
        end
      end
    end
  end

  assign cpu_inst_o  = r_inst;
  assign out_data_o  = r_out_data;
  assign out_valid_o = r_out_valid;
  assign cyc_o       = r_cyc;

endmodule
